// File: rtl/store_unit_ctrl.sv
// Store-path front end: aligns issued stores, obtains the physical address from
// the DTLB, writes one store into store_buffer and reports completion or a misalignment fault.
module store_unit_ctrl #(
  parameter int XLEN          = 32,
  parameter int PLEN          = 34,
  parameter int TRANS_ID_BITS = 3
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic                     valid_i,
  output logic                     issue_ready_o,
  input  logic [XLEN-1:0]          vaddr_i,
  input  logic [XLEN-1:0]          data_i,
  input  logic [1:0]               size_i,
  input  logic [TRANS_ID_BITS-1:0] trans_id_i,
  output logic                     translation_req_o,
  output logic [XLEN-1:0]          vaddr_o,
  input  logic                     dtlb_hit_i,
  input  logic [PLEN-1:0]          paddr_i,
  input  logic                     sb_ready_i,
  output logic                     sb_valid_o,
  output logic                     sb_valid_without_flush_o,
  output logic [PLEN-1:0]          sb_paddr_o,
  output logic [XLEN-1:0]          sb_data_o,
  output logic [3:0]               sb_be_o,
  output logic [1:0]               sb_data_size_o,
  output logic                     valid_o,
  output logic [TRANS_ID_BITS-1:0] trans_id_o,
  output logic                     ex_o,
  output logic [XLEN-1:0]          ex_tval_o,
  output logic [1:0]               state_o
);

  typedef enum logic [1:0] {
    IDLE             = 2'd0,
    WAIT_TRANSLATION = 2'd1,
    WAIT_STORE_READY = 2'd2
  } state_e;

  // Handshake: a store is taken on a cycle with valid_i & issue_ready_o & !flush_i;
  // the store buffer takes sb_valid_o when sb_ready_i is high in the same cycle.

  state_e                   state_q, state_d;
  logic [XLEN-1:0]          vaddr_q;
  logic [XLEN-1:0]          data_q;
  logic [3:0]               be_q;
  logic [1:0]               size_q;
  logic [TRANS_ID_BITS-1:0] trans_id_q;
  logic [PLEN-1:0]          paddr_q;
  logic                     ex_valid_q;
  logic [XLEN-1:0]          ex_tval_q;
  logic [TRANS_ID_BITS-1:0] ex_tid_q;

  logic [1:0]      off;
  logic [3:0]      be_a;
  logic [XLEN-1:0] data_a;
  logic            misaligned;
  logic            accept;

  assign off    = vaddr_i[1:0];
  assign accept = valid_i & issue_ready_o & ~flush_i;

  always_comb begin
    be_a       = 4'h0;
    misaligned = 1'b0;
    data_a     = data_i << {off, 3'b000};
    case (size_i)
      2'd0: be_a = 4'b0001 << off;
      2'd1: begin
        be_a       = 4'b0011 << off;
        misaligned = off[0];
      end
      2'd2: begin
        be_a       = 4'hF;
        misaligned = (off != 2'd0);
      end
      default: misaligned = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      vaddr_q    <= '0;
      data_q     <= '0;
      be_q       <= '0;
      size_q     <= '0;
      trans_id_q <= '0;
      paddr_q    <= '0;
      ex_valid_q <= 1'b0;
      ex_tval_q  <= '0;
      ex_tid_q   <= '0;
    end else begin
      state_q    <= state_d;
      ex_valid_q <= accept & misaligned;
      if (accept & ~misaligned) begin
        vaddr_q    <= vaddr_i;
        data_q     <= data_a;
        be_q       <= be_a;
        size_q     <= size_i;
        trans_id_q <= trans_id_i;
      end
      if (accept & misaligned) begin
        ex_tval_q <= vaddr_i;
        ex_tid_q  <= trans_id_i;
      end
      if (state_q == WAIT_TRANSLATION && dtlb_hit_i) paddr_q <= paddr_i;
    end
  end

  always_comb begin
    state_d                  = state_q;
    issue_ready_o            = (state_q == IDLE);
    translation_req_o        = 1'b0;
    sb_valid_without_flush_o = 1'b0;
    sb_valid_o               = 1'b0;
    valid_o                  = 1'b0;
    trans_id_o               = '0;
    ex_o                     = 1'b0;
    ex_tval_o                = '0;
    case (state_q)
      IDLE: begin
        if (accept && !misaligned) state_d = WAIT_TRANSLATION;
        // A pending fault writeback only ever occurs here, so it cannot meet a normal completion.
        if (ex_valid_q && !flush_i) begin
          valid_o    = 1'b1;
          ex_o       = 1'b1;
          ex_tval_o  = ex_tval_q;
          trans_id_o = ex_tid_q;
        end
      end
      WAIT_TRANSLATION: begin
        translation_req_o = 1'b1;
        if (dtlb_hit_i) state_d = WAIT_STORE_READY;
      end
      WAIT_STORE_READY: begin
        sb_valid_without_flush_o = sb_ready_i;
        sb_valid_o               = sb_ready_i & ~flush_i;
        if (sb_ready_i && !flush_i) begin
          valid_o    = 1'b1;
          trans_id_o = trans_id_q;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (flush_i) state_d = IDLE;
  end

  assign vaddr_o        = vaddr_q;
  assign sb_paddr_o     = paddr_q;
  assign sb_data_o      = data_q;
  assign sb_be_o        = be_q;
  assign sb_data_size_o = size_q;
  assign state_o        = state_q;

endmodule

// File: tb/tb_store_unit_ctrl.sv
// Bench for store_unit_ctrl: directed scenarios plus random stores, with expected
// store-buffer writes and writebacks produced by a byte-lane reference model.
module tb_store_unit_ctrl;

  localparam int SBW = 34 + 32 + 4 + 2;
  localparam int WBW = 1 + 3 + 32;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        flush_i = 1'b0;
  logic        valid_i = 1'b0;
  logic        issue_ready_o;
  logic [31:0] vaddr_i = '0;
  logic [31:0] data_i = '0;
  logic [1:0]  size_i = '0;
  logic [2:0]  trans_id_i = '0;
  logic        translation_req_o;
  logic [31:0] vaddr_o;
  logic        dtlb_hit_i = 1'b0;
  logic [33:0] paddr_i = '0;
  logic        sb_ready_i = 1'b0;
  logic        sb_valid_o;
  logic        sb_valid_without_flush_o;
  logic [33:0] sb_paddr_o;
  logic [31:0] sb_data_o;
  logic [3:0]  sb_be_o;
  logic [1:0]  sb_data_size_o;
  logic        valid_o;
  logic [2:0]  trans_id_o;
  logic        ex_o;
  logic [31:0] ex_tval_o;
  logic [1:0]  state_o;

  int n_checks = 0;
  int n_errors = 0;
  logic [SBW-1:0] exp_q[$];
  logic [WBW-1:0] wb_q[$];

  store_unit_ctrl dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i), .valid_i(valid_i),
    .issue_ready_o(issue_ready_o), .vaddr_i(vaddr_i), .data_i(data_i),
    .size_i(size_i), .trans_id_i(trans_id_i), .translation_req_o(translation_req_o),
    .vaddr_o(vaddr_o), .dtlb_hit_i(dtlb_hit_i), .paddr_i(paddr_i),
    .sb_ready_i(sb_ready_i), .sb_valid_o(sb_valid_o),
    .sb_valid_without_flush_o(sb_valid_without_flush_o), .sb_paddr_o(sb_paddr_o),
    .sb_data_o(sb_data_o), .sb_be_o(sb_be_o), .sb_data_size_o(sb_data_size_o),
    .valid_o(valid_o), .trans_id_o(trans_id_o), .ex_o(ex_o), .ex_tval_o(ex_tval_o),
    .state_o(state_o)
  );

  // clock / reset
  always #5 clk_i = ~clk_i;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [SBW-1:0] got, input logic [SBW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: a store of 2^size bytes is legal only when naturally aligned; lanes
  // start at the address offset and the data moves up by the same number of bytes.
  function automatic void model(input logic [31:0] va, input logic [31:0] d, input logic [1:0] sz,
                                output logic mis, output logic [3:0] be, output logic [31:0] al);
    int nbytes = 1 << sz;
    int o = int'(va % 4);
    mis = (sz == 2'd3) || ((o % nbytes) != 0);
    be = 4'h0;
    if (!mis) for (int b = 0; b < nbytes; b++) be[o + b] = 1'b1;
    al = d << (8 * o);
  endfunction

  // scoreboard monitors, sampled on the falling edge
  always @(negedge clk_i) begin
    if (sb_valid_o) begin
      if (exp_q.size() == 0) check("sb_unexpected", SBW'(sb_valid_o), SBW'(0));
      else check("sb_write", {sb_paddr_o, sb_data_o, sb_be_o, sb_data_size_o}, exp_q.pop_front());
    end
    if (valid_o) begin
      if (wb_q.size() == 0) check("wb_unexpected", SBW'(valid_o), SBW'(0));
      else begin
        logic [WBW-1:0] e;
        e = wb_q.pop_front();
        check("wb_ex_tag", SBW'({ex_o, trans_id_o}), SBW'(e[35:32]));
        if (e[35]) check("wb_tval", SBW'(ex_tval_o), SBW'(e[31:0]));
      end
    end
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ctrl"}, SBW'({issue_ready_o, translation_req_o, sb_valid_o,
          sb_valid_without_flush_o, valid_o, ex_o, trans_id_o}), SBW'(9'b1_0000_0000));
    check({tag, "_vaddr"}, SBW'(vaddr_o), SBW'(0));
    check({tag, "_sb"}, {sb_paddr_o, sb_data_o, sb_be_o, sb_data_size_o}, SBW'(0));
    check({tag, "_tval"}, SBW'(ex_tval_o), SBW'(0));
  endtask

  // Drives one store from IDLE. miss/nready: cycles of TLB miss and store-buffer
  // backpressure. do_flush: flush in the completion (or fault writeback) cycle.
  task automatic do_store(input logic [31:0] va, input logic [31:0] d, input logic [1:0] sz,
                          input logic [2:0] tag, input logic [33:0] pa, input int miss,
                          input int nready, input bit do_flush);
    logic mis;
    logic [3:0] be;
    logic [31:0] al;
    model(va, d, sz, mis, be, al);
    check("idle_ready", SBW'(issue_ready_o), SBW'(1));
    valid_i = 1'b1; vaddr_i = va; data_i = d; size_i = sz; trans_id_i = tag;
    if (!do_flush) begin
      if (mis) wb_q.push_back({1'b1, tag, va});
      else begin
        exp_q.push_back({pa, al, be, sz});
        wb_q.push_back({1'b0, tag, 32'h0});
      end
    end
    step();
    valid_i = 1'b0;
    if (mis) begin
      flush_i = do_flush;
      #1;
      check("ex_valid", SBW'({valid_o, ex_o}), SBW'({!do_flush, !do_flush}));
      check("ex_no_sb", SBW'({sb_valid_o, issue_ready_o, translation_req_o}), SBW'(3'b010));
      step();
      flush_i = 1'b0;
      return;
    end
    for (int i = 0; i <= miss; i++) begin
      dtlb_hit_i = (i == miss);
      paddr_i = (i == miss) ? pa : 34'(~pa);
      #1;
      check("xlat_req", SBW'({translation_req_o, issue_ready_o, valid_o}), SBW'(3'b100));
      check("xlat_vaddr", SBW'(vaddr_o), SBW'(va));
      step();
    end
    dtlb_hit_i = 1'b0;
    for (int j = 0; j <= nready; j++) begin
      sb_ready_i = (j == nready);
      flush_i = do_flush && (j == nready);
      #1;
      if (j == nready && do_flush)
        check("flush_sr", SBW'({sb_valid_without_flush_o, sb_valid_o, valid_o}), SBW'(3'b100));
      else
        check("sr_strobe", SBW'({sb_valid_o, valid_o, ex_o, translation_req_o, issue_ready_o}),
              SBW'({j == nready, j == nready, 3'b000}));
      step();
    end
    sb_ready_i = 1'b0;
    flush_i = 1'b0;
    #1;
    check("back_idle", SBW'({issue_ready_o, valid_o, sb_valid_o}), SBW'(3'b100));
  endtask

  initial begin
    #1;
    check_reset_outputs("reset");
    #21 rst_ni = 1'b1;
    step();

    do_store(32'h1000, 32'hDEADBEEF, 2'd2, 3'd5, 34'h3_0000_1000, 0, 0, 1'b0);
    do_store(32'h1003, 32'h0000_00AB, 2'd0, 3'd1, 34'h1_0000_1003, 0, 0, 1'b0);
    do_store(32'h2002, 32'h0000_1234, 2'd1, 3'd2, 34'h0_0000_2002, 0, 0, 1'b0);
    do_store(32'h2001, 32'h0000_5678, 2'd1, 3'd3, 34'h0, 0, 0, 1'b0);
    do_store(32'h2005, 32'h1, 2'd3, 3'd4, 34'h0, 0, 0, 1'b0);
    do_store(32'h3003, 32'h2, 2'd0, 3'd6, 34'h0, 0, 0, 1'b0);
    do_store(32'h3006, 32'h2, 2'd2, 3'd6, 34'h0, 0, 0, 1'b0);
    do_store(32'h4000, 32'hCAFEF00D, 2'd2, 3'd7, 34'h2_1234_4000, 3, 2, 1'b0);
    do_store(32'h5000, 32'h11223344, 2'd2, 3'd1, 34'h0_0000_5000, 1, 0, 1'b1);
    do_store(32'h5003, 32'h99, 2'd2, 3'd2, 34'h0, 0, 0, 1'b1);

    // back-to-back faults give consecutive writebacks
    valid_i = 1'b1; vaddr_i = 32'h6001; size_i = 2'd2; trans_id_i = 3'd1;
    wb_q.push_back({1'b1, 3'd1, 32'h6001});
    step();
    vaddr_i = 32'h6003; size_i = 2'd1; trans_id_i = 3'd2;
    wb_q.push_back({1'b1, 3'd2, 32'h6003});
    #1 check("b2b_ex_1", SBW'({valid_o, ex_o, issue_ready_o}), SBW'(3'b111));
    step();
    valid_i = 1'b0;
    #1 check("b2b_ex_2", SBW'({valid_o, ex_o, issue_ready_o}), SBW'(3'b111));
    step();

    // reset while waiting for translation discards the store
    valid_i = 1'b1; vaddr_i = 32'h7000; data_i = 32'h55; size_i = 2'd2; trans_id_i = 3'd3;
    step();
    valid_i = 1'b0;
    #1 check("pre_rst_xlat", SBW'(translation_req_o), SBW'(1));
    rst_ni = 1'b0;
    #1 check_reset_outputs("mid_reset");
    step();
    rst_ni = 1'b1;
    step();
    check("post_rst_idle", SBW'({issue_ready_o, translation_req_o}), SBW'(2'b10));

    for (int n = 0; n < 60; n++) begin
      logic [31:0] va;
      va = $urandom;
      do_store(va, $urandom, 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
               {2'($urandom_range(0, 3)), 32'($urandom)}, $urandom_range(0, 3),
               $urandom_range(0, 3), ($urandom_range(0, 7) == 0));
    end

    step();
    check("sb_drained", SBW'(exp_q.size()), SBW'(0));
    check("wb_drained", SBW'(wb_q.size()), SBW'(0));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/store_unit_ctrl.md
# store_unit_ctrl

Front-end control for committed-path stores. It accepts a store operation from the LSU issue port, aligns the data and computes byte enables, and obtains the physical address from the DTLB. It then writes the store into the speculative queue of `store_buffer` and returns the store's transaction ID (or a misalignment exception) to the scoreboard. It sits directly upstream of `store_buffer` and drives its `valid_i`, `valid_without_flush_i`, `paddr_i`, `data_i`, `be_i` and `data_size_i`.

## Interface
- `XLEN`, 32, data and virtual-address width
- `PLEN`, 34, physical-address width
- `TRANS_ID_BITS`, 3, scoreboard transaction-ID width

- `clk_i` in 1: the single clock
- `rst_ni` in 1: reset, asynchronous, active-low
- `flush_i` in 1: pipeline flush
- `valid_i` in 1: store issue request
- `issue_ready_o` out 1: request accepted when `valid_i & issue_ready_o & !flush_i`
- `vaddr_i` in XLEN: store virtual address
- `data_i` in XLEN: store data, LSB-justified
- `size_i` in 2: 0 = byte, 1 = half, 2 = word, 3 = illegal
- `trans_id_i` in TRANS_ID_BITS: scoreboard tag
- `translation_req_o` out 1: DTLB lookup request
- `vaddr_o` out XLEN: latched virtual address for the DTLB
- `dtlb_hit_i` in 1: translation valid this cycle
- `paddr_i` in PLEN: translated physical address
- `sb_ready_i` in 1: `store_buffer.ready_o`
- `sb_valid_o` out 1: write strobe into the store buffer
- `sb_valid_without_flush_o` out 1: same strobe, not gated by `flush_i`
- `sb_paddr_o` out PLEN; `sb_data_o` out XLEN; `sb_be_o` out 4; `sb_data_size_o` out 2
- `valid_o` out 1: scoreboard writeback strobe
- `trans_id_o` out TRANS_ID_BITS: writeback tag
- `ex_o` out 1: writeback carries a misaligned-store exception
- `ex_tval_o` out XLEN: faulting virtual address

## Operation
- FSM states are IDLE, WAIT_TRANSLATION and WAIT_STORE_READY. Reset state is IDLE.
- `issue_ready_o` = (state == IDLE).
- **IDLE, on accept.** Compute `off = vaddr_i[1:0]`.
  - byte: `be = 4'b0001 << off`, `data = data_i << (8*off)`
  - half: legal only if `off[0] == 0`; `be = 4'b0011 << off`, `data << (8*off)`
  - word: legal only if `off == 0`; `be = 4'hF`
  - size 3, or an illegal offset, is misaligned.
- **Legal accept.** Latch vaddr, aligned data, be, size and trans_id. Go to WAIT_TRANSLATION.
- **Misaligned accept.** Stay in IDLE. Next cycle pulse `valid_o = 1`, `ex_o = 1`, `ex_tval_o = vaddr`, `trans_id_o = tag`. Nothing is sent to the store buffer.
- **WAIT_TRANSLATION.** `translation_req_o = 1` and `vaddr_o` = latched address. On `dtlb_hit_i`, latch `paddr_i` and go to WAIT_STORE_READY. Otherwise hold.
- **WAIT_STORE_READY.**
  - `sb_valid_without_flush_o = sb_ready_i`.
  - `sb_valid_o = sb_ready_i & !flush_i`.
  - `sb_*` data outputs = latched values.
  - When `sb_ready_i` is high and there is no flush: same cycle, `valid_o = 1`, `ex_o = 0`, `trans_id_o` = latched tag; go to IDLE.
- **Flush.** `flush_i` in any state forces next state to IDLE. It suppresses `sb_valid_o`, `valid_o` and any pending exception writeback, and blocks acceptance.
- `sb_*` data outputs are don't-care while `sb_valid_without_flush_o = 0`. They are held registered, so they do not toggle.

## Timing
- **Reset (async).** State is IDLE. Registered outputs and latches are 0. `issue_ready_o = 1`. All other outputs are 0.
- **Latency.**
  - Accept at cycle T. `translation_req_o` high at T+1.
  - Hit at T+1 means `sb_valid_o` and `valid_o` at T+2 if `sb_ready_i`. This is the 2-cycle minimum.
  - Each cycle of TLB miss or `sb_ready_i = 0` adds 1 cycle.
- **Exception path.** Fixed 1-cycle latency. Back-to-back misaligned stores give consecutive `valid_o` pulses. A normal completion cannot collide with an exception writeback because a normal store needs at least 2 cycles from IDLE.
- At most one store is in flight. No request is accepted outside IDLE.
- **Reset mid-operation.** The in-flight store is discarded and nothing reaches the store buffer.

## Test plan
- **Word store.** Reset, then accept vaddr 0x1000, data 0xDEADBEEF, size 2, tag 5; hit at T+1 with paddr 0x3_0000_1000; `sb_ready_i = 1`. Expect `translation_req_o` at T+1. At T+2 expect `sb_valid_o = 1`, paddr 0x3_0000_1000, be 0xF, data 0xDEADBEEF, size 2, `valid_o = 1`, tag 5, `ex_o = 0`.
- **Byte alignment.** Byte store to vaddr 0x1003, data 0x000000AB. Expect `sb_be_o = 0x8` and `sb_data_o = 0xAB000000`.
- **Half-word at offset 2.** Half store to vaddr 0x2002, data 0x1234. Expect be 0xC and data 0x12340000.
- **Misaligned.** Half store to vaddr 0x2001, tag 3. Expect next cycle `valid_o = 1`, `ex_o = 1`, `ex_tval_o = 0x2001`, tag 3. Expect `sb_valid_o` never asserted and `issue_ready_o` held at 1.
- **Backpressure and miss.** `dtlb_hit_i` low for 3 cycles, then `sb_ready_i` low for 2 cycles. Expect `translation_req_o` high for 4 cycles and `issue_ready_o = 0` throughout. Expect a single `sb_valid_o` pulse at T+7 coincident with `valid_o`.
- **Flush.** Assert `flush_i` in WAIT_STORE_READY with `sb_ready_i = 1`. Expect `sb_valid_without_flush_o = 1`, `sb_valid_o = 0`, `valid_o = 0`, and IDLE with `issue_ready_o = 1` on the next cycle. Repeat with `rst_ni` dropped in WAIT_TRANSLATION: all outputs must immediately read their reset values.
